// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: FSM states, reset/NOP constants and
// the register-index field positions reused by ID and the hazard unit.
package if_stage_pkg;

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_DROP,
        S_HOLD
    } fetchState_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned RS1_LSB   = 15;
    localparam int unsigned RS2_LSB   = 20;

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, else hold.
module if_id_reg #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] loadPc,
    input  logic [31:0]     loadInstr,
    output logic [XLEN-1:0] ifIdPc,
    output logic [31:0]     ifIdInstr,
    output logic            ifIdValid
);

    // Register update with flush > load > bubble > hold priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifIdPc    <= '0;
            ifIdInstr <= NOP_INSTR;
            ifIdValid <= 1'b0;
        end else if (flush) begin
            ifIdPc    <= '0;
            ifIdInstr <= NOP_INSTR;
            ifIdValid <= 1'b0;
        end else if (load) begin
            ifIdPc    <= loadPc;
            ifIdInstr <= loadInstr;
            ifIdValid <= 1'b1;
        end else if (bubble) begin
            ifIdValid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_PC,
    input  logic            stall_IF_ID,
    input  logic            EX_branch_taken,
    input  logic [XLEN-1:0] EX_branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [31:0]     IF_ID_Instr,
    output logic            IF_ID_valid,
    output logic [4:0]      IF_ID_RegRs1,
    output logic [4:0]      IF_ID_RegRs2
);

    fetchState_t     state, stateNext;
    logic [XLEN-1:0] pc, pcNext;
    logic [XLEN-1:0] redirectPc, redirectPcNext;
    logic [XLEN-1:0] holdPc, holdPcNext;
    logic [31:0]     holdInstr, holdInstrNext;

    logic            stall;
    logic [XLEN-1:0] targetAligned;
    logic [XLEN-1:0] pcPlus4;
    logic            unusedTargetLsbs;

    logic            ifIdFlush, ifIdLoad, ifIdBubble;
    logic [XLEN-1:0] ifIdLoadPc;
    logic [31:0]     ifIdLoadInstr;

    assign stall            = stall_PC | stall_IF_ID;
    assign targetAligned    = {EX_branch_target[XLEN-1:2], 2'b00};
    assign unusedTargetLsbs = ^EX_branch_target[1:0];
    assign pcPlus4          = pc + XLEN'(4);

    assign imem_addr = pc;
    assign imem_req  = (state == S_FETCH) || (state == S_DROP);

    // State, PC, redirect and holding-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_START;
            pc         <= RESET_PC;
            redirectPc <= '0;
            holdPc     <= '0;
            holdInstr  <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            redirectPc <= redirectPcNext;
            holdPc     <= holdPcNext;
            holdInstr  <= holdInstrNext;
        end
    end

    // Next-state, PC selection and IF/ID control; flush > stall > advance.
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        redirectPcNext = redirectPc;
        holdPcNext     = holdPc;
        holdInstrNext  = holdInstr;
        ifIdFlush      = 1'b0;
        ifIdLoad       = 1'b0;
        ifIdBubble     = 1'b0;
        ifIdLoadPc     = pc;
        ifIdLoadInstr  = imem_rdata;

        case (state)
            S_START: begin
                stateNext = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    if (EX_branch_taken) begin
                        pcNext    = targetAligned;
                        ifIdFlush = 1'b1;
                    end else if (stall) begin
                        holdPcNext    = pc;
                        holdInstrNext = imem_rdata;
                        stateNext     = S_HOLD;
                    end else begin
                        ifIdLoad = 1'b1;
                        pcNext   = pcPlus4;
                    end
                end else if (EX_branch_taken) begin
                    // Request at pc is still outstanding: park the target
                    // until the stale response has been consumed.
                    redirectPcNext = targetAligned;
                    ifIdFlush      = 1'b1;
                    stateNext      = S_DROP;
                end else if (!stall) begin
                    ifIdBubble = 1'b1;
                end
            end
            S_DROP: begin
                if (EX_branch_taken) begin
                    redirectPcNext = targetAligned;
                    ifIdFlush      = 1'b1;
                end
                if (imem_ready) begin
                    pcNext    = EX_branch_taken ? targetAligned : redirectPc;
                    stateNext = S_FETCH;
                end
            end
            S_HOLD: begin
                if (EX_branch_taken) begin
                    holdPcNext    = '0;
                    holdInstrNext = '0;
                    pcNext        = targetAligned;
                    ifIdFlush     = 1'b1;
                    stateNext     = S_FETCH;
                end else if (!stall) begin
                    ifIdLoad      = 1'b1;
                    ifIdLoadPc    = holdPc;
                    ifIdLoadInstr = holdInstr;
                    pcNext        = pcPlus4;
                    stateNext     = S_FETCH;
                end
            end
            default: begin
                stateNext = S_START;
            end
        endcase
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) ifIdReg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ifIdFlush),
        .load      (ifIdLoad),
        .bubble    (ifIdBubble),
        .loadPc    (ifIdLoadPc),
        .loadInstr (ifIdLoadInstr),
        .ifIdPc    (IF_ID_PC),
        .ifIdInstr (IF_ID_Instr),
        .ifIdValid (IF_ID_valid)
    );

    assign IF_ID_RegRs1 = IF_ID_Instr[RS1_LSB +: REG_IDX_W];
    assign IF_ID_RegRs2 = IF_ID_Instr[RS2_LSB +: REG_IDX_W];

endmodule
